// File: rtl/tnoc_axi_pkg.sv
// Shared AXI-side definitions for the tnoc slave path.
//   tnoc_packet_config          : AXI ID / address / data widths carried by tnoc_axi_if
//   tnoc_axi_outstanding_limits : per-direction outstanding caps for wrappers
//   tnoc_count_width()          : width of a counter that must hold 0..max_value
package tnoc_axi_pkg;

    typedef struct packed {
        int id_width;
        int address_width;
        int data_width;
    } tnoc_packet_config;

    localparam tnoc_packet_config TNOC_DEFAULT_PACKET_CONFIG = '{
        id_width:      4,
        address_width: 32,
        data_width:    32
    };

    typedef struct packed {
        logic [7:0] writes;
        logic [7:0] reads;
        logic [7:0] w_bursts;
    } tnoc_axi_outstanding_limits;

    localparam tnoc_axi_outstanding_limits TNOC_DEFAULT_OUTSTANDING_LIMITS = '{
        writes:   8'd4,
        reads:    8'd4,
        w_bursts: 8'd4
    };

    function automatic int tnoc_count_width(int max_value);
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/tnoc_axi_if.sv
// AXI4 bundle used between the upstream master, the outstanding limiter and
// tnoc_axi_slave_adapter. Widths come from PACKET_CONFIG.
//   master modport : drives AW/W/AR and B/R ready
//   slave  modport : drives AW/W/AR ready and B/R
interface tnoc_axi_if
    import tnoc_axi_pkg::*;
#(
    parameter tnoc_packet_config PACKET_CONFIG = TNOC_DEFAULT_PACKET_CONFIG
);
    localparam int ID_W   = PACKET_CONFIG.id_width;
    localparam int ADDR_W = PACKET_CONFIG.address_width;
    localparam int DATA_W = PACKET_CONFIG.data_width;

    logic              awvalid;
    logic              awready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;

    logic            bvalid;
    logic            bready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;

    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input  bvalid, bid, bresp, output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst, input arready,
        input  rvalid, rid, rdata, rresp, rlast, output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
        input  wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bid, bresp, input bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, output arready,
        output rvalid, rid, rdata, rresp, rlast, input rready
    );

endinterface

// File: rtl/tnoc_up_down_counter.sv
// Saturating up/down counter, range 0..MAX.
//   i_clk       : clock
//   i_clear     : synchronous clear (highest priority)
//   i_up        : increment request (ignored at MAX)
//   i_down      : decrement request (holds at 0)
//   o_count     : registered count
//   o_at_max    : o_count == MAX
//   o_underflow : i_down while o_count == 0 (combinational)
module tnoc_up_down_counter
    import tnoc_axi_pkg::*;
#(
    parameter int MAX = 4
)(
    input  logic                            i_clk,
    input  logic                            i_clear,
    input  logic                            i_up,
    input  logic                            i_down,
    output logic [tnoc_count_width(MAX)-1:0] o_count,
    output logic                            o_at_max,
    output logic                            o_underflow
);
    localparam int            CW        = tnoc_count_width(MAX);
    localparam logic [CW-1:0] MAX_COUNT = CW'(MAX);

    logic [CW-1:0] r_count;
    logic          w_is_zero;

    assign w_is_zero   = (r_count == '0);
    assign o_count     = r_count;
    assign o_at_max    = (r_count == MAX_COUNT);
    assign o_underflow = i_down && w_is_zero;

    // Simultaneous up and down is a net-zero update.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_up && !i_down && !o_at_max) begin
            r_count <= r_count + CW'(1);
        end else if (i_down && !i_up && !w_is_zero) begin
            r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/tnoc_axi_outstanding_limiter.sv
// Caps outstanding AXI writes, reads and un-finished W bursts between an
// upstream master and tnoc_axi_slave_adapter; holds W until its AW has been
// accepted. Payload passes straight through; only valid/ready are gated, and
// the gating uses registered counts only, so no valid->ready loop is formed.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   slave_if            : from the upstream master
//   master_if           : towards tnoc_axi_slave_adapter
//   o_write_outstanding : AW accepted, B not yet accepted
//   o_read_outstanding  : AR accepted, last R not yet accepted
//   o_protocol_error    : sticky, set by a B or last R with nothing outstanding
module tnoc_axi_outstanding_limiter
    import tnoc_axi_pkg::*;
#(
    parameter tnoc_packet_config PACKET_CONFIG = TNOC_DEFAULT_PACKET_CONFIG,
    parameter int MAX_WRITES   = int'(TNOC_DEFAULT_OUTSTANDING_LIMITS.writes),
    parameter int MAX_READS    = int'(TNOC_DEFAULT_OUTSTANDING_LIMITS.reads),
    parameter int MAX_W_BURSTS = int'(TNOC_DEFAULT_OUTSTANDING_LIMITS.w_bursts)
)(
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    tnoc_axi_if.slave                              slave_if,
    tnoc_axi_if.master                             master_if,
    output logic [tnoc_count_width(MAX_WRITES)-1:0] o_write_outstanding,
    output logic [tnoc_count_width(MAX_READS)-1:0]  o_read_outstanding,
    output logic                                   o_protocol_error
);
    localparam int WR_W = tnoc_count_width(MAX_WRITES);
    localparam int RD_W = tnoc_count_width(MAX_READS);
    localparam int WB_W = tnoc_count_width(MAX_W_BURSTS);

    logic [WR_W-1:0] w_wr_cnt;
    logic [RD_W-1:0] w_rd_cnt;
    logic [WB_W-1:0] w_wb_cnt;
    logic            w_wr_at_max, w_rd_at_max, w_wb_at_max;
    logic            w_wr_underflow, w_rd_underflow, w_wb_underflow;
    logic            w_aw_allow, w_w_allow, w_ar_allow;
    logic            w_aw_hs, w_w_last_hs, w_b_hs, w_ar_hs, w_r_last_hs;
    logic            r_protocol_error;

    // Sized from PACKET_CONFIG so an interface built with another config shows up as a width mismatch.
    logic [PACKET_CONFIG.data_width-1:0] w_wdata;

    // Reset is folded into every gate so nothing can handshake while counters clear.
    assign w_aw_allow = !i_rst && !w_wr_at_max && !w_wb_at_max;
    assign w_w_allow  = !i_rst && (w_wb_cnt != '0);
    assign w_ar_allow = !i_rst && !w_rd_at_max;

    // AW
    assign master_if.awvalid = slave_if.awvalid && w_aw_allow;
    assign slave_if.awready  = master_if.awready && w_aw_allow;
    assign master_if.awid    = slave_if.awid;
    assign master_if.awaddr  = slave_if.awaddr;
    assign master_if.awlen   = slave_if.awlen;
    assign master_if.awsize  = slave_if.awsize;
    assign master_if.awburst = slave_if.awburst;

    // W
    assign w_wdata           = slave_if.wdata;
    assign master_if.wvalid  = slave_if.wvalid && w_w_allow;
    assign slave_if.wready   = master_if.wready && w_w_allow;
    assign master_if.wdata   = w_wdata;
    assign master_if.wstrb   = slave_if.wstrb;
    assign master_if.wlast   = slave_if.wlast;

    // B
    assign slave_if.bvalid   = master_if.bvalid && !i_rst;
    assign master_if.bready  = slave_if.bready && !i_rst;
    assign slave_if.bid      = master_if.bid;
    assign slave_if.bresp    = master_if.bresp;

    // AR
    assign master_if.arvalid = slave_if.arvalid && w_ar_allow;
    assign slave_if.arready  = master_if.arready && w_ar_allow;
    assign master_if.arid    = slave_if.arid;
    assign master_if.araddr  = slave_if.araddr;
    assign master_if.arlen   = slave_if.arlen;
    assign master_if.arsize  = slave_if.arsize;
    assign master_if.arburst = slave_if.arburst;

    // R
    assign slave_if.rvalid   = master_if.rvalid && !i_rst;
    assign master_if.rready  = slave_if.rready && !i_rst;
    assign slave_if.rid      = master_if.rid;
    assign slave_if.rdata    = master_if.rdata;
    assign slave_if.rresp    = master_if.rresp;
    assign slave_if.rlast    = master_if.rlast;

    // Handshakes observed on the adapter side
    assign w_aw_hs     = master_if.awvalid && master_if.awready;
    assign w_w_last_hs = master_if.wvalid && master_if.wready && master_if.wlast;
    assign w_b_hs      = master_if.bvalid && master_if.bready;
    assign w_ar_hs     = master_if.arvalid && master_if.arready;
    assign w_r_last_hs = master_if.rvalid && master_if.rready && master_if.rlast;

    tnoc_up_down_counter #(.MAX(MAX_WRITES)) u_wr_counter (
        .i_clk(i_clk), .i_clear(i_rst), .i_up(w_aw_hs), .i_down(w_b_hs),
        .o_count(w_wr_cnt), .o_at_max(w_wr_at_max), .o_underflow(w_wr_underflow)
    );

    tnoc_up_down_counter #(.MAX(MAX_W_BURSTS)) u_w_burst_counter (
        .i_clk(i_clk), .i_clear(i_rst), .i_up(w_aw_hs), .i_down(w_w_last_hs),
        .o_count(w_wb_cnt), .o_at_max(w_wb_at_max), .o_underflow(w_wb_underflow)
    );

    tnoc_up_down_counter #(.MAX(MAX_READS)) u_rd_counter (
        .i_clk(i_clk), .i_clear(i_rst), .i_up(w_ar_hs), .i_down(w_r_last_hs),
        .o_count(w_rd_cnt), .o_at_max(w_rd_at_max), .o_underflow(w_rd_underflow)
    );

    // The W-burst term cannot fire while W is gated on a non-zero count; it is
    // kept so a broken gate is reported rather than silently absorbed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_protocol_error <= 1'b0;
        end else if (w_wr_underflow || w_rd_underflow || w_wb_underflow) begin
            r_protocol_error <= 1'b1;
        end
    end

    assign o_write_outstanding = w_wr_cnt;
    assign o_read_outstanding  = w_rd_cnt;
    assign o_protocol_error    = r_protocol_error;

    a_no_w_without_aw: assert property (@(posedge i_clk) disable iff (i_rst)
        !(master_if.wvalid && master_if.wready && (w_wb_cnt == '0)));

    a_no_aw_at_write_limit: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_aw_hs && (w_wr_cnt == WR_W'(MAX_WRITES))));

endmodule

// File: doc/tnoc_axi_outstanding_limiter.md
# tnoc_axi_outstanding_limiter

Sits between an upstream AXI master and `tnoc_axi_slave_adapter`, on the AXI side of the slave adapter. It caps the number of outstanding write and read transactions so that the adapter's response tracking and the fabric are never over-subscribed. It also enforces AW-before-W ordering toward the adapter. All channels pass through combinationally; only the gating decisions depend on registered counters.

## Interface
- `PACKET_CONFIG`, default `TNOC_DEFAULT_PACKET_CONFIG`: packet configuration that sets the AXI ID, address and data widths.
- `MAX_WRITES`, default 4: maximum outstanding write transactions (AW accepted, B not yet accepted); range 1..255.
- `MAX_READS`, default 4: maximum outstanding read transactions (AR accepted, last R not yet accepted); range 1..255.
- `MAX_W_BURSTS`, default 4: maximum AW bursts whose W data has not yet completed; range 1..255.

Ports:
- `i_clk`, input, 1: clock. One clock domain.
- `i_rst`, input, 1: reset, synchronous, active-high.
- `slave_if`, `tnoc_axi_if` (slave modport), per `PACKET_CONFIG`: faces the upstream AXI master.
- `master_if`, `tnoc_axi_if` (master modport), per `PACKET_CONFIG`: faces `tnoc_axi_slave_adapter`.
- `o_write_outstanding`, output, `$clog2(MAX_WRITES+1)`: current outstanding write count.
- `o_read_outstanding`, output, `$clog2(MAX_READS+1)`: current outstanding read count.
- `o_protocol_error`, output, 1: sticky error flag.

## Operation
- **Payload pass-through:** all payload fields (id, addr, len, size, burst, data, strb, last, resp) pass unmodified in both directions.
- **AW channel:**
  - `aw_allow = (wr_cnt < MAX_WRITES) && (w_bursts < MAX_W_BURSTS)`.
  - `master.awvalid = slave.awvalid && aw_allow`.
  - `slave.awready = master.awready && aw_allow`.
- **W channel:**
  - `w_allow = (w_bursts > 0)`, using the registered value.
  - `master.wvalid = slave.wvalid && w_allow`.
  - `slave.wready = master.wready && w_allow`.
  - A W beat presented before its AW waits until the AW handshake has been registered.
- **B channel:** pure pass-through.
- **AR channel:** gated by `rd_cnt < MAX_READS`, with the same valid/ready form as AW.
- **R channel:** pure pass-through.
- **Counter updates** (all on the rising `i_clk` edge, counted on handshakes at the `master_if` side):
  - `wr_cnt`: +1 on an AW handshake, −1 on a B handshake, net 0 when both occur in the same cycle.
  - `w_bursts`: +1 on an AW handshake, −1 on a W handshake with `wlast`=1, net 0 when both occur in the same cycle.
  - `rd_cnt`: +1 on an AR handshake, −1 on an R handshake with `rlast`=1, net 0 when both occur in the same cycle.
- **Underflow:** a B handshake with `wr_cnt`=0, or a `rlast` R handshake with `rd_cnt`=0:
  - the counter holds at 0;
  - `o_protocol_error` is set and stays set until reset.
- **Overflow:** impossible by construction, because the gating forbids the increment at the maximum.
- **During `i_rst`=1:** all forwarded valids and readies are forced to 0 in both directions, so no handshake can complete.

## Timing
- Zero-cycle combinational path on every channel.
- The gating term depends only on registered counters, so there is no valid→ready combinational loop through this block.
- A counter change is visible one cycle after the handshake. Example: AW accepted in cycle N → W may be forwarded from cycle N+1.
- At a limit, the blocked channel reopens in the cycle after the freeing handshake (B, last R, or `wlast` W).
- **Reset values:**
  - all counters 0;
  - `o_write_outstanding` = 0, `o_read_outstanding` = 0;
  - `o_protocol_error` = 0;
  - all gated valids/readies 0.
- **Reset mid-transaction:** counters clear immediately. The upstream and downstream sides are reset together; no draining is attempted.

## Structure
- **Shared package:** `tnoc_axi_pkg` gains a `tnoc_axi_outstanding_limits` struct (writes, reads, w_bursts) so that top-level wrappers can pass limits uniformly.
- **Sub-module:** `tnoc_up_down_counter`, parameterised by MAX. It has inputs `up`, `down`, `clear`, and outputs `count`, `at_max`, `underflow`. It is instantiated three times.
- **Assertions:**
  - no W handshake while `w_bursts`=0;
  - no AW handshake while `wr_cnt`=`MAX_WRITES`.

## Test plan
- **Write limit:** `MAX_WRITES`=2, 3 back-to-back single-beat writes, B held off → 2 AW pass, third `awready`=0, `o_write_outstanding`=2; first B accepted → third AW accepted the next cycle.
- **W before AW:** `wvalid` asserted 3 cycles before `awvalid` → `master.wvalid`=0 until one cycle after the AW handshake; the 4-beat burst then completes and `w_bursts` returns to 0.
- **Read limit:** `MAX_READS`=1, two 8-beat reads → second AR blocked until the cycle after the `rlast` handshake; non-last R beats do not free the slot.
- **Simultaneous events:** AW handshake and B handshake in the same cycle with `wr_cnt`=1 → `wr_cnt` stays 1; the same check for AR together with a `rlast` R.
- **Error:** inject a spurious B with `wr_cnt`=0 → `o_protocol_error`=1 from the next cycle, count stays 0; flag clears only after `i_rst`.
- **Reset mid-transaction:** assert `i_rst` with `wr_cnt`=2 and `rd_cnt`=1 → next cycle all counts are 0, all valids/readies are 0 during reset, and normal traffic resumes afterwards.
